// File: rtl/pow_pkg.sv
// Shared types and helpers for the sequential power unit.
package pow_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } pow_state_e;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Position of the highest set bit plus one; zero for a zero input.
   function automatic int unsigned bit_len(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         if (v[i]) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/pow_mul.sv
// Combinational unsigned W x W multiplier reporting the low half and whether the high half is nonzero.
module pow_mul #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic         hi_nz
);

   logic [2*W-1:0] prod;

   always_comb begin
      prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      lo    = prod[W-1:0];
      hi_nz = |prod[2*W-1:W];
   end

endmodule

// File: rtl/pow_unit.sv
// LSB-first square-and-multiply power unit, one exponent bit per clock, with
// valid/ready handshakes, per-transaction wrap/saturate mode and an overflow flag.
module pow_unit
   import pow_pkg::*;
#(
   parameter int unsigned BASE_W = 16,
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned RES_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BASE_W-1:0] base,
   input  logic [EXP_W-1:0]  exp,
   input  logic              sat_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  result,
   output logic              ovf,
   output logic              busy
);

   if (RES_W < BASE_W) begin : gen_bad_width
      $error("pow_unit: RES_W must be >= BASE_W");
   end

   pow_state_e       state_q, state_d;
   logic [RES_W-1:0] acc_q, acc_d;
   logic [RES_W-1:0] pw_q, pw_d;
   logic [EXP_W-1:0] e_q, e_d;
   logic             mode_q, mode_d;
   logic             acc_ovf_q, acc_ovf_d;
   logic             pw_ovf_q, pw_ovf_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;

   logic [RES_W-1:0] mul_lo, sq_lo;
   logic             mul_hi_nz, sq_hi_nz;

   pow_mul #(.W(RES_W)) u_mul_acc (
      .a     (acc_q),
      .b     (pw_q),
      .lo    (mul_lo),
      .hi_nz (mul_hi_nz)
   );

   pow_mul #(.W(RES_W)) u_mul_sq (
      .a     (pw_q),
      .b     (pw_q),
      .lo    (sq_lo),
      .hi_nz (sq_hi_nz)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      pw_d      = pw_q;
      e_d       = e_q;
      mode_d    = mode_q;
      acc_ovf_d = acc_ovf_q;
      pw_ovf_d  = pw_ovf_q;
      result_d  = result_q;
      ovf_d     = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               acc_d     = RES_W'(1);
               pw_d      = RES_W'(base);
               e_d       = exp;
               mode_d    = sat_mode;
               acc_ovf_d = 1'b0;
               pw_ovf_d  = 1'b0;
               if (exp == '0) begin
                  state_d  = StDone;
                  result_d = RES_W'(1);
                  ovf_d    = 1'b0;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            // A saturated pw only poisons the result once it is actually multiplied in.
            if (e_q[0]) begin
               acc_d     = mul_lo;
               acc_ovf_d = acc_ovf_q | mul_hi_nz | pw_ovf_q;
            end
            pw_d     = sq_lo;
            pw_ovf_d = pw_ovf_q | sq_hi_nz;
            e_d      = e_q >> 1;
            if (e_d == '0) begin
               state_d  = StDone;
               result_d = ((mode_q == MODE_SAT) && acc_ovf_d) ? {RES_W{1'b1}} : acc_d;
               ovf_d    = acc_ovf_d;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         pw_q      <= '0;
         e_q       <= '0;
         mode_q    <= MODE_WRAP;
         acc_ovf_q <= 1'b0;
         pw_ovf_q  <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         pw_q      <= pw_d;
         e_q       <= e_d;
         mode_q    <= mode_d;
         acc_ovf_q <= acc_ovf_d;
         pw_ovf_q  <= pw_ovf_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign result    = result_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pow_unit.sv
// Directed and randomised checks of pow_unit against an independent repeated-multiply model.
module tb_pow_unit;
   import pow_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] base;
   logic [7:0]  exp;
   logic        sat_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        ovf;
   logic        busy;

   int n_total = 0;
   int n_bad   = 0;

   pow_unit #(.BASE_W(16), .EXP_W(8), .RES_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .base      (base),
      .exp       (exp),
      .sat_mode  (sat_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Exact value mod 2^32 plus a true-value overflow flag via capped 64-bit tracking.
   task automatic model(input logic [15:0] b, input logic [7:0] e, input logic s,
                        output logic [31:0] r, output logic o);
      logic [31:0] w;
      logic [63:0] t;
      w = 32'd1;
      t = 64'd1;
      for (int i = 0; i < int'(e); i++) begin
         w = w * {16'd0, b};
         t = t * {48'd0, b};
         if (t > 64'h1_0000_0000) t = 64'h1_0000_0000;
      end
      o = (t >= 64'h1_0000_0000);
      r = (s && o) ? 32'hFFFF_FFFF : w;
   endtask

   // Present one operand set in IDLE; optionally keep in_valid high with junk while busy.
   task automatic issue(input logic [15:0] b, input logic [7:0] e, input logic s, input bit noise,
                        output logic [31:0] r, output logic o, output int lat);
      base     = b;
      exp      = e;
      sat_mode = s;
      in_valid = 1'b1;
      tick();
      lat = 1;
      if (noise) begin
         base     = 16'd7;
         exp      = 8'd3;
         sat_mode = 1'b1;
      end else begin
         in_valid = 1'b0;
      end
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      in_valid = 1'b0;
      r = result;
      o = ovf;
   endtask

   task automatic do_vec(input string tag, input logic [15:0] b, input logic [7:0] e,
                         input logic s, input logic [31:0] want_r, input logic want_o);
      logic [31:0] r;
      logic        o;
      int          lat;
      out_ready = 1'b1;
      issue(b, e, s, 1'b0, r, o, lat);
      check({tag, ".lat"}, 64'(lat), 64'(bit_len(64'(e)) + 1));
      check({tag, ".res"}, 64'(r), 64'(want_r));
      check({tag, ".ovf"}, 64'(o), 64'(want_o));
      tick();
      check({tag, ".rdy"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] r, mr;
      logic        o, mo;
      logic [15:0] rb;
      logic [7:0]  re;
      logic        rs;
      int          lat;
      bit          seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      base      = '0;
      exp       = '0;
      sat_mode  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst.in_ready", 64'(in_ready), 64'd1);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.result", 64'(result), 64'd0);
      check("rst.ovf", 64'(ovf), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      reset = 1'b0;
      tick();

      do_vec("p2_10", 16'd2, 8'd10, MODE_WRAP, 32'd1024, 1'b0);
      do_vec("p3_0", 16'd3, 8'd0, MODE_WRAP, 32'd1, 1'b0);
      do_vec("p0_0", 16'd0, 8'd0, MODE_WRAP, 32'd1, 1'b0);
      do_vec("p0_5", 16'd0, 8'd5, MODE_SAT, 32'd0, 1'b0);
      do_vec("p2_31", 16'd2, 8'd31, MODE_WRAP, 32'h8000_0000, 1'b0);
      do_vec("p2_40w", 16'd2, 8'd40, MODE_WRAP, 32'd0, 1'b1);
      do_vec("p2_40s", 16'd2, 8'd40, MODE_SAT, 32'hFFFF_FFFF, 1'b1);
      do_vec("pffff_2", 16'hFFFF, 8'd2, MODE_SAT, 32'hFFFE_0001, 1'b0);
      do_vec("p1_255", 16'd1, 8'd255, MODE_SAT, 32'd1, 1'b0);
      do_vec("p3_20", 16'd3, 8'd20, MODE_SAT, 32'd3486784401, 1'b0);
      do_vec("p3_21s", 16'd3, 8'd21, MODE_SAT, 32'hFFFF_FFFF, 1'b1);

      // Backpressure: result held while out_ready is low.
      out_ready = 1'b0;
      issue(16'd5, 8'd3, MODE_WRAP, 1'b0, r, o, lat);
      check("bp.lat", 64'(lat), 64'd3);
      for (int i = 0; i < 5; i++) begin
         check("bp.valid", 64'(out_valid), 64'd1);
         check("bp.result", 64'(result), 64'd125);
         check("bp.ovf", 64'(ovf), 64'd0);
         check("bp.in_ready", 64'(in_ready), 64'd0);
         check("bp.busy", 64'(busy), 64'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp.release", 64'(in_ready), 64'd1);

      // Operands offered while running must be ignored.
      issue(16'd2, 8'd10, MODE_WRAP, 1'b1, r, o, lat);
      check("noise.result", 64'(r), 64'd1024);
      check("noise.ovf", 64'(o), 64'd0);
      tick();
      check("noise.idle", 64'(in_ready), 64'd1);

      // Abort mid-run.
      base     = 16'd3;
      exp      = 8'd200;
      sat_mode = MODE_WRAP;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("abort.busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort.in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      check("abort.no_valid", 64'(seen), 64'd0);
      do_vec("abort.p3_4", 16'd3, 8'd4, MODE_WRAP, 32'd81, 1'b0);

      // Randomised traffic with random consumer stalls.
      for (int t = 0; t < 1000; t++) begin
         case ($urandom_range(0, 3))
            0:       rb = 16'($urandom_range(0, 3));
            1:       rb = 16'($urandom_range(0, 255));
            default: rb = 16'($urandom);
         endcase
         re = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
         rs = 1'($urandom);
         model(rb, re, rs, mr, mo);
         out_ready = 1'b0;
         issue(rb, re, rs, 1'($urandom), r, o, lat);
         check("rnd.lat", 64'(lat), 64'(bit_len(64'(re)) + 1));
         check("rnd.result", 64'(r), 64'(mr));
         check("rnd.ovf", 64'(o), 64'(mo));
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            tick();
            check("rnd.hold", 64'(result), 64'(mr));
         end
         out_ready = 1'b1;
         tick();
         check("rnd.idle", 64'(in_ready), 64'd1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pow_unit.md
# pow_unit

Parametrised sequential integer power unit computing base^exp by LSB-first square-and-multiply, one exponent bit per clock. It replaces the C-side `$pow_x` VPI function with synthesizable RTL. It adds:
- width generics
- a valid/ready handshake on both sides
- per-transaction wrap or saturate mode
- an overflow flag

`$pow_x` remains the bench's golden model.

## Interface
Parameters:
- BASE_W, 16, base operand width (unsigned)
- EXP_W, 8, exponent width (unsigned)
- RES_W, 32, result width; must satisfy RES_W >= BASE_W (elaboration error otherwise)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  unit can accept (high only in IDLE)
- base  in  BASE_W  base, zero-extended to RES_W internally
- exp  in  EXP_W  exponent
- sat_mode  in  1  0 = wrap (result mod 2^RES_W), 1 = saturate to all-ones on overflow
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  RES_W  base^exp per mode
- ovf  out  1  true value ≥ 2^RES_W
- busy  out  1  state != IDLE

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid (accept):
    - acc ← 1, pw ← base, e ← exp.
    - mode ← sat_mode, acc_ovf ← 0, pw_ovf ← 0.
  - Next state: RUN if exp != 0, else DONE.
- **RUN, per cycle:**
  - If e[0]: acc ← low RES_W of acc·pw. acc_ovf |= (high half of product != 0) | pw_ovf.
  - pw ← low RES_W of pw·pw. pw_ovf |= (high half != 0).
  - e ← e >> 1. Go to DONE when the shifted e == 0.
  - pw_ovf only matters once consumed by a later multiply. Overflow of a square that is never used must not set ovf.
  - base = 0: pw stays 0 and never overflows.
- **DONE:**
  - out_valid = 1, ovf = acc_ovf.
  - result = all-ones if (mode & acc_ovf), else acc.
  - On out_ready: go to IDLE. result and ovf hold their values until the next DONE.
- **Handshake:**
  - in_ready is low outside IDLE. Inputs are ignored then and need not be held.
  - out_valid stays high, and result/ovf stay stable, until out_ready is sampled high.
  - The out_ready handshake and a new in_valid are never taken in the same cycle. The unit re-enters IDLE first.
- **Arithmetic:** unsigned throughout. Wrap mode is exact modulo 2^RES_W, with no saturation. 0^0 = 1.

## Timing
- **Reset values:** in_ready 1 (IDLE), out_valid 0, result 0, ovf 0, busy 0, internal acc/pw/e 0.
- **Reset mid-operation:** aborts in RUN or DONE. The unit is in IDLE, with in_ready = 1, the cycle after reset deasserts. No result is produced.
- **Latency:** let L = bit length of exp (position of the highest set bit + 1).
  - Accept at edge k → RUN for L cycles → out_valid high from edge k+L+1.
  - exp = 0: out_valid high from edge k+1.
  - Worst case is EXP_W+1 cycles.
- **Throughput:** with out_ready tied high, one result per L+2 cycles (DONE, IDLE accept, RUN×L).
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output except through state.

## Structure
- **pow_pkg:**
  - state enum (IDLE/RUN/DONE)
  - mode constants MODE_WRAP = 0, MODE_SAT = 1
  - a function computing bit length, for bench use
- **pow_mul** (sub-module), parameter W:
  - Unsigned W×W multiply.
  - Outputs the low W bits and `hi_nz` (high W bits nonzero).
  - Purely combinational.
  - Instantiated twice in pow_unit: acc·pw and pw·pw.
- pow_unit holds the FSM, the registers and the output muxing.

## Test plan
- base=2, exp=10, wrap, out_ready=1: result 1024, ovf 0, out_valid at accept+5.
- exp=0 with base=3 and then base=0: result 1 both times, latency 1. Also base=0, exp=5: result 0, ovf 0.
- RES_W=32, base=2:
  - exp=31: 0x8000_0000, ovf 0.
  - exp=40, wrap: 0, ovf 1.
  - exp=40, sat: 0xFFFF_FFFF, ovf 1.
  - base=0xFFFF, exp=2: 0xFFFE_0001, ovf 0. This checks that an unused square overflow does not flag.
- Backpressure:
  - Hold out_ready low for 5 cycles in DONE. result, ovf and out_valid must stay stable and in_ready must stay 0.
  - Drive in_valid during RUN. The operands must be ignored.
- Reset asserted for one cycle during RUN of base=3, exp=200: out_valid never rises. The cycle after reset, in_ready = 1. A following 3^4 returns 81.
- Randomised, 1000 transactions, random out_ready: compare against `$pow_x`, reduced mod 2^32, and the ovf model.
